pixel_packer: RTL and testbench

Downstream stage of the core array. Collects the serial `output_bit` stream qualified by `valid_bit`, packs consecutive bits into grayscale pixel words (first bit = MSB), and buffers them in a small show-ahead FIFO. The VGA scan-out logic drains that FIFO with a ready/valid pop handshake. The block decouples the instruction-paced bit stream from pixel-clock-paced scan-out and flags any starvation or overrun.

---
 rtl/gpu_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/pixel_packer.sv | 129 ++++++++++++
 tb/tb_pixel_packer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_pkg
// Description : Shared constants for the pixel pipeline (packer and VGA
//               timing). Provides the default pixel word width, the default
//               pixel FIFO depth and the FIFO occupancy-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

    localparam int DEFAULT_BITS_PER_PIXEL = 2;
    localparam int DEFAULT_FIFO_DEPTH     = 8;

    // An occupancy counter must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_LEVEL_WIDTH = level_width(DEFAULT_FIFO_DEPTH);

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO. The head word is presented on
//               rdata whenever the FIFO is non-empty (0 when empty). A push
//               into a full FIFO is accepted only when a pop happens in the
//               same cycle. Storage is not reset.
// Ports       : clk, rst (async, active-high), clear (sync flush),
//               push/wdata, pop, rdata, full, empty, level
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import gpu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_BITS_PER_PIXEL,
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A same-cycle pop frees the slot, so a push on full is still accepted.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule
`default_nettype wire

// File: rtl/pixel_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_packer
// Description : Packs the serial output_bit stream (qualified by valid_bit,
//               first bit = MSB) into BITS_PER_PIXEL-wide grayscale words and
//               buffers them in a show-ahead FIFO drained by a ready/valid
//               pop handshake. frame_start flushes packer, FIFO and status.
// Ports       : clk, rst (async, active-high), valid_bit, output_bit,
//               frame_start, pixel_ready -> pixel_valid, pixel_data,
//               fifo_full, level, overflow (sticky), underflow (sticky)
// Config      : PIXEL_PACKER_STATUS_EN - when defined, level / overflow /
//               underflow are live; otherwise they are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_packer
    import gpu_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEFAULT_BITS_PER_PIXEL,
    parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid_bit,
    input  logic                               output_bit,
    input  logic                               frame_start,
    input  logic                               pixel_ready,
    output logic                               pixel_valid,
    output logic [BITS_PER_PIXEL-1:0]          pixel_data,
    output logic                               fifo_full,
    output logic [level_width(FIFO_DEPTH)-1:0] level,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int LW = level_width(FIFO_DEPTH);

    logic [BITS_PER_PIXEL-1:0] word;
    logic                      complete;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [LW-1:0]             fifo_level;

    generate
        if (BITS_PER_PIXEL == 1) begin : g_bpp_one
            assign word     = output_bit;
            assign complete = valid_bit;
        end else begin : g_bpp_multi
            localparam int CW = $clog2(BITS_PER_PIXEL);
            localparam logic [CW-1:0] LAST_BIT = CW'(BITS_PER_PIXEL - 1);

            logic [BITS_PER_PIXEL-2:0] shift_reg;
            logic [CW-1:0]             bit_cnt;

            assign word     = {shift_reg, output_bit};
            assign complete = valid_bit & (bit_cnt == LAST_BIT);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else if (frame_start) begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end else if (valid_bit) begin
                    // Low bits of the assembled word are the shift state after this bit.
                    shift_reg <= word[BITS_PER_PIXEL-2:0];
                    bit_cnt   <= complete ? '0 : bit_cnt + CW'(1);
                end
            end
        end
    endgenerate

    // frame_start wins over a same-cycle bit or pop.
    assign push = complete & ~frame_start;
    assign pop  = pixel_ready & ~frame_start;

    sync_fifo #(
        .WIDTH (BITS_PER_PIXEL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (frame_start),
        .push  (push),
        .wdata (word),
        .pop   (pop),
        .rdata (pixel_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    assign pixel_valid = ~empty;
    assign fifo_full   = full;

`ifdef PIXEL_PACKER_STATUS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (frame_start) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // Dropped push: full and no pop draining a slot this cycle.
            if (push && full && !(pop && !empty)) overflow_q  <= 1'b1;
            if (pop && empty)                      underflow_q <= 1'b1;
        end
    end

    assign level     = fifo_level;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_level;
    assign unused_level = ^fifo_level;

    assign level     = '0;
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pixel_packer
// Description : Directed self-checking bench for pixel_packer (BPP=2,
//               DEPTH=8). Status expectations follow PIXEL_PACKER_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_packer;
    import gpu_pkg::*;

    localparam int BPP   = 2;
    localparam int DEPTH = 8;
    localparam int LW    = level_width(DEPTH);
`ifdef PIXEL_PACKER_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           valid_bit;
    logic           output_bit;
    logic           frame_start;
    logic           pixel_ready;
    logic           pixel_valid;
    logic [BPP-1:0] pixel_data;
    logic           fifo_full;
    logic [LW-1:0]  level;
    logic           overflow;
    logic           underflow;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_packer #(
        .BITS_PER_PIXEL (BPP),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_bit   (valid_bit),
        .output_bit  (output_bit),
        .frame_start (frame_start),
        .pixel_ready (pixel_ready),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .fifo_full   (fifo_full),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] st(input logic [31:0] v);
        return STATUS ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [1:0] d,
                           input logic f, input logic [31:0] lv, input logic o, input logic u);
        chk({tag, ".valid"}, 32'(pixel_valid), 32'(v));
        chk({tag, ".data"},  32'(pixel_data),  32'(d));
        chk({tag, ".full"},  32'(fifo_full),   32'(f));
        chk({tag, ".level"}, 32'(level),       st(lv));
        chk({tag, ".ovf"},   32'(overflow),    st(32'(o)));
        chk({tag, ".udf"},   32'(underflow),   st(32'(u)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid_bit  = 1'b1;
        output_bit = b;
        tick();
        valid_bit  = 1'b0;
    endtask

    task automatic send_pixel(input logic [1:0] w);
        send_bit(w[1]);
        send_bit(w[0]);
    endtask

    task automatic flush();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic pop_one();
        pixel_ready = 1'b1;
        tick();
        pixel_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] seq_a [8];
        logic [1:0] seq_b [8];
        seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        seq_b = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};

        rst = 1'b1; valid_bit = 1'b0; output_bit = 1'b0;
        frame_start = 1'b0; pixel_ready = 1'b0;
        tick(); tick();
        chk_all("reset", 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;

        // First pixel: bits 1,0 -> 2'b10 visible after the second bit.
        send_bit(1'b1);
        chk("first.partial_valid", 32'(pixel_valid), 32'd0);
        send_bit(1'b0);
        chk_all("first", 1'b1, 2'b10, 1'b0, 1, 1'b0, 1'b0);

        // Fill to full, then a 9th pixel is dropped.
        flush();
        for (int i = 0; i < 8; i++) send_pixel(seq_a[i]);
        chk_all("filled", 1'b1, seq_a[0], 1'b1, 8, 1'b0, 1'b0);
        send_pixel(2'd1);
        chk_all("overflow", 1'b1, seq_a[0], 1'b1, 8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_a.data", 32'(pixel_data), 32'(seq_a[i]));
            pop_one();
        end
        chk_all("drained_a", 1'b0, 2'd0, 1'b0, 0, 1'b1, 1'b0);

        // Full with a completing pixel and a pop in the same cycle.
        flush();
        chk("flush.ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) send_pixel(2'(i));
        send_bit(1'b1);
        valid_bit = 1'b1; output_bit = 1'b0; pixel_ready = 1'b1;
        tick();
        valid_bit = 1'b0; pixel_ready = 1'b0;
        chk_all("full_push_pop", 1'b1, seq_b[0], 1'b1, 8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_b.data", 32'(pixel_data), 32'(seq_b[i]));
            pop_one();
        end
        chk_all("drained_b", 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);

        // Underflow is sticky until frame_start.
        pop_one();
        chk_all("underflow", 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        chk("underflow.sticky", 32'(underflow), st(1));
        flush();
        chk_all("underflow.cleared", 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);

        // Partial bit and the same-cycle bit are discarded by frame_start.
        send_bit(1'b1);
        frame_start = 1'b1; valid_bit = 1'b1; output_bit = 1'b1;
        tick();
        frame_start = 1'b0; valid_bit = 1'b0;
        chk("fs_discard.valid", 32'(pixel_valid), 32'd0);
        send_pixel(2'b01);
        chk_all("fs_realign", 1'b1, 2'b01, 1'b0, 1, 1'b0, 1'b0);
        pop_one();
        chk("fs_pop.valid", 32'(pixel_valid), 32'd0);

        // Asynchronous reset mid-pixel with a word buffered.
        send_pixel(2'b11);
        chk("pre_rst.data", 32'(pixel_data), 32'd3);
        send_bit(1'b1);
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 2'd0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;

        // Empty FIFO: push and pop request together -> push wins, underflow set.
        send_bit(1'b0);
        valid_bit = 1'b1; output_bit = 1'b1; pixel_ready = 1'b1;
        tick();
        valid_bit = 1'b0; pixel_ready = 1'b0;
        chk_all("empty_push_pop", 1'b1, 2'b01, 1'b0, 1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
